// File: rtl/dbg_pkg.sv
// Shared definitions for the CPU debug unit: FSM state encoding and
// helpers that derive index and trace-entry field widths.
package dbg_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_STEP   = 2'd2
   } dbg_state_e;

   // Width of the saturating dropped-entry counter.
   localparam int DROP_W = 8;

   // Index width for n items, never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Trace entry layout: {pc, wr_en, wr_addr, wr_data}.
   function automatic int entry_w(input int pc_w, input int reg_w, input int data_w);
      return pc_w + 1 + reg_w + data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO. A push into a full FIFO is dropped and
// counted unless a pop happens in the same cycle.
module trace_fifo
   import dbg_pkg::*;
#(
   parameter int WIDTH = 68,
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WIDTH-1:0]  din,
   input  logic              pop,
   output logic              valid,
   output logic [WIDTH-1:0]  dout,
   output logic [CNT_W-1:0]  count,
   output logic [DROP_W-1:0] drops
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_push;
   logic             drop;

   assign full    = (count == CNT_W'(DEPTH));
   assign valid   = (count != '0);
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted pushes only.
   // NOTE: the memory has no reset; pointers and count define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers, occupancy and drop counter; pointers wrap naturally at DEPTH.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drops  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop && (drops != '1)) drops <= drops + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_debug_unit.sv
// CPU debug unit: halt/step/resume control with PC breakpoints, a
// synchronised halt button and a trace FIFO of retired instructions.
module cpu_debug_unit
   import dbg_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int DEPTH  = 16,
   parameter int NBP    = 2,
   localparam int REG_W = idx_w(NREGS),
   localparam int IDX_W = idx_w(NBP),
   localparam int ENT_W = entry_w(PC_W, REG_W, DATA_W),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_button,
   input  logic              retire,
   input  logic [PC_W-1:0]   retire_pc,
   input  logic              wr_en,
   input  logic [REG_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              resume,
   input  logic              step,
   input  logic              bp_we,
   input  logic [IDX_W-1:0]  bp_idx,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic              bp_en,
   output logic              cpu_stall,
   output logic              halted,
   input  logic              trace_rd,
   output logic              trace_valid,
   output logic [ENT_W-1:0]  trace_entry,
   output logic [CNT_W-1:0]  trace_count,
   output logic [DROP_W-1:0] trace_drops
);

   dbg_state_e        state;
   dbg_state_e        state_next;
   logic [1:0]        sync;
   logic              sync_prev;
   logic              halt_req;
   logic [PC_W-1:0]   bp_addr_q [NBP];
   logic [NBP-1:0]    bp_en_q;
   logic              bp_hit;
   logic [REG_W-1:0]  ent_addr;
   logic [DATA_W-1:0] ent_data;

   // Two-flop synchroniser, edge detect, and a registered one-cycle halt pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync      <= '0;
         sync_prev <= 1'b0;
         halt_req  <= 1'b0;
      end else begin
         sync      <= {sync[0], halt_button};
         sync_prev <= sync[1];
         halt_req  <= sync[1] & ~sync_prev;
      end
   end

   // Breakpoint slot registers; a write becomes visible the following cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bp_en_q <= '0;
         for (int i = 0; i < NBP; i++) bp_addr_q[i] <= '0;
      end else if (bp_we) begin
         for (int i = 0; i < NBP; i++) begin
            if (bp_idx == IDX_W'(i)) begin
               bp_addr_q[i] <= bp_addr;
               bp_en_q[i]   <= bp_en;
            end
         end
      end
   end

   // Compare the retiring PC against the registered (pre-write) breakpoints.
   // NOTE: combinational outputs get a default first so no latch is inferred.
   always_comb begin
      bp_hit = 1'b0;
      for (int i = 0; i < NBP; i++) begin
         if (bp_en_q[i] && (bp_addr_q[i] == retire_pc)) bp_hit = 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_next;
   end

   // Next-state logic; resume has priority over step, breakpoints only act in RUN.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:    if (halt_req || (retire && bp_hit)) state_next = ST_HALTED;
         ST_HALTED: begin
            if (resume)    state_next = ST_RUN;
            else if (step) state_next = ST_STEP;
         end
         ST_STEP:   if (halt_req || retire) state_next = ST_HALTED;
         default:   state_next = ST_RUN;
      endcase
   end

   assign halted    = (state == ST_HALTED);
   assign cpu_stall = (state == ST_HALTED);

   // Register fields are zeroed when the instruction wrote nothing.
   assign ent_addr = wr_en ? wr_addr : '0;
   assign ent_data = wr_en ? wr_data : '0;

   trace_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_trace_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (retire),
      .din   ({retire_pc, wr_en, ent_addr, ent_data}),
      .pop   (trace_rd),
      .valid (trace_valid),
      .dout  (trace_entry),
      .count (trace_count),
      .drops (trace_drops)
   );

endmodule

// File: tb/tb_cpu_debug_unit.sv
// Scoreboard bench for cpu_debug_unit: the driver queues expected trace
// entries, a negedge monitor pops and compares them as the DUT pops its FIFO.
module tb_cpu_debug_unit;

   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int NREGS  = 8;
   localparam int REG_W  = 3;
   localparam int DEPTH  = 16;
   localparam int NBP    = 2;
   localparam int EW     = PC_W + 1 + REG_W + DATA_W;
   localparam int CW     = 5;

   logic              clk;
   logic              rst;
   logic              halt_button;
   logic              retire;
   logic [PC_W-1:0]   retire_pc;
   logic              wr_en;
   logic [REG_W-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              resume;
   logic              step;
   logic              bp_we;
   logic [0:0]        bp_idx;
   logic [PC_W-1:0]   bp_addr;
   logic              bp_en;
   logic              cpu_stall;
   logic              halted;
   logic              trace_rd;
   logic              trace_valid;
   logic [EW-1:0]     trace_entry;
   logic [CW-1:0]     trace_count;
   logic [7:0]        trace_drops;

   logic [EW-1:0] exp_q [$];
   int            exp_drops = 0;
   int            n_checks  = 0;
   int            n_pass    = 0;

   cpu_debug_unit #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .DEPTH  (DEPTH),
      .NBP    (NBP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .halt_button (halt_button),
      .retire      (retire),
      .retire_pc   (retire_pc),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .resume      (resume),
      .step        (step),
      .bp_we       (bp_we),
      .bp_idx      (bp_idx),
      .bp_addr     (bp_addr),
      .bp_en       (bp_en),
      .cpu_stall   (cpu_stall),
      .halted      (halted),
      .trace_rd    (trace_rd),
      .trace_valid (trace_valid),
      .trace_entry (trace_entry),
      .trace_count (trace_count),
      .trace_drops (trace_drops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] ent(input logic [31:0] pc, input logic we,
                                         input logic [2:0] a, input logic [31:0] d);
      logic [2:0]  ea;
      logic [31:0] ed;
      ea = we ? a : 3'd0;
      ed = we ? d : 32'd0;
      return {pc, we, ea, ed};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Monitor: every accepted pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst && trace_rd && trace_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL trace_unexpected: got 0x%0h, want nothing", trace_entry);
         end else begin
            check("trace_entry", trace_entry, exp_q.pop_front());
         end
      end
   end

   // One clock: optional retire and pop; expected FIFO state is updated first.
   task automatic cyc(input logic r, input logic [31:0] pc, input logic we,
                      input logic [2:0] a, input logic [31:0] d, input logic rd);
      if (r) begin
         if (exp_q.size() < DEPTH || (rd && exp_q.size() > 0)) exp_q.push_back(ent(pc, we, a, d));
         else if (exp_drops < 255) exp_drops++;
      end
      retire    = r;
      retire_pc = pc;
      wr_en     = we;
      wr_addr   = a;
      wr_data   = d;
      trace_rd  = rd;
      @(posedge clk);
      #1;
      retire   = 1'b0;
      trace_rd = 1'b0;
      resume   = 1'b0;
      step     = 1'b0;
      bp_we    = 1'b0;
      check("trace_count", trace_count, exp_q.size());
      check("trace_drops", trace_drops, exp_drops);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
      check("drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      rst = 1'b0; halt_button = 1'b0; retire = 1'b0; retire_pc = '0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; resume = 1'b0; step = 1'b0; bp_we = 1'b0;
      bp_idx = '0; bp_addr = '0; bp_en = 1'b0; trace_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_halted", halted, 0);
      check("reset_stall", cpu_stall, 0);
      check("reset_valid", trace_valid, 0);
      check("reset_count", trace_count, 0);
      check("reset_drops", trace_drops, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Breakpoints: slot0=0x10; slot1=0x20 written while 0x20 retires (old value used).
      bp_we = 1'b1; bp_idx = 1'd0; bp_addr = 32'h10; bp_en = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      bp_we = 1'b1; bp_idx = 1'd1; bp_addr = 32'h20; bp_en = 1'b1;
      cyc(1'b1, 32'h20, 1'b1, 3'd2, 32'h22, 1'b0);
      check("bp_same_cycle_nohalt", halted, 0);
      cyc(1'b1, 32'h0C, 1'b1, 3'd3, 32'hAA, 1'b0);
      check("bp_0c_nohalt", halted, 0);
      cyc(1'b1, 32'h10, 1'b0, 3'd5, 32'h55, 1'b0);
      check("bp_10_halted", halted, 1);
      check("bp_10_stall", cpu_stall, 1);
      check("bp_head", trace_entry, {32'h20, 1'b1, 3'd2, 32'h22});
      drain();
      check("halted_after_drain", halted, 1);

      // Step: one retire in STEP returns to HALTED.
      step = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("step_state_not_halted", halted, 0);
      check("step_no_stall", cpu_stall, 0);
      cyc(1'b1, 32'h14, 1'b1, 3'd1, 32'h1234, 1'b0);
      check("step_rehalted", halted, 1);
      check("step_one_entry", trace_count, 1);
      drain();

      // Resume and step together: resume wins, so a plain retire does not halt.
      step = 1'b1; resume = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("resume_wins", halted, 0);
      cyc(1'b1, 32'h30, 1'b1, 3'd7, 32'hDEAD, 1'b0);
      check("run_no_halt", halted, 0);
      step = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      cyc(1'b1, 32'h34, 1'b0, 3'd0, 32'h0, 1'b0);
      check("step_in_run_ignored", halted, 0);
      drain();

      // Halt button: stall within 4 cycles, resume clears it next cycle.
      halt_button = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
         seen = cpu_stall;
      end
      check("button_stall_in_4", seen, 1);
      halt_button = 1'b0;
      resume = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("button_resume", cpu_stall, 0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("button_fall_no_halt", halted, 0);

      // Overflow: 18 retires into 16 slots.
      for (int i = 0; i < 18; i++)
         cyc(1'b1, 32'(32'h100 + 4 * i), 1'b1, 3'(i), 32'(i * 3), 1'b0);
      check("ovf_count", trace_count, 16);
      check("ovf_drops", trace_drops, 2);
      check("ovf_head_pc", trace_entry[EW-1 -: PC_W], 32'h100);

      // Push and pop together while full.
      cyc(1'b1, 32'h200, 1'b0, 3'd0, 32'h0, 1'b1);
      check("full_pp_count", trace_count, 16);
      check("full_pp_drops", trace_drops, 2);
      check("full_pp_head_pc", trace_entry[EW-1 -: PC_W], 32'h104);

      // Reduce to 4, halt on the breakpoint (5 entries), then reset asynchronously.
      for (int k = 0; k < 40 && exp_q.size() > 4; k++) cyc(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
      cyc(1'b1, 32'h10, 1'b1, 3'd4, 32'h44, 1'b0);
      check("pre_reset_halted", halted, 1);
      check("pre_reset_count", trace_count, 5);
      #2;
      rst = 1'b0;
      #1;
      check("rst_halted", halted, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_valid", trace_valid, 0);
      check("rst_count", trace_count, 0);
      check("rst_drops", trace_drops, 0);
      exp_q.delete();
      exp_drops = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Breakpoints were cleared by reset: 0x10 no longer halts.
      cyc(1'b1, 32'h10, 1'b1, 3'd6, 32'h66, 1'b0);
      check("post_reset_bp_cleared", halted, 0);
      drain();
      check("final_empty", trace_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
